// File: rtl/layer_sequencer_if.sv
// Result stream of layer_sequencer: one captured neuron sum per valid/ready handshake.
interface layer_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_NEURON = 30
);
  localparam int unsigned SW = 2 * DATA_WIDTH;
  localparam int unsigned IW = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;

  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_data;
  logic [IW-1:0] out_idx;

  modport master (output out_valid, output out_data, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_data, input out_idx, output out_ready);
endinterface

// File: rtl/layer_sequencer.sv
// Fully-connected layer sequencer: freeze/run the neuron array, capture all sums, stream them out.
// Optional LAYER_SEQ_RELU_EN: rectify negative sums to zero at capture.
module layer_sequencer #(
  parameter int unsigned NUM_WEIGHT = 784,
  parameter int unsigned NUM_NEURON = 30,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  output logic                                 busy,
  output logic [$clog2(NUM_WEIGHT)-1:0]        in_addr,
  input  logic [DATA_WIDTH-1:0]                in_data,
  output logic                                 freeze,
  output logic [DATA_WIDTH-1:0]                myinput,
  input  logic [NUM_NEURON*2*DATA_WIDTH-1:0]   sums_in,
  layer_sequencer_if.master                    out_if,
  output logic                                 done
);
  localparam int unsigned AW = $clog2(NUM_WEIGHT);
  localparam int unsigned SW = 2 * DATA_WIDTH;
  localparam int unsigned IW = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WEIGHT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_NEURON - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPTURE, S_DRAIN} state_e;

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic          freeze_q, freeze_d;
  logic [AW-1:0] in_addr_q, in_addr_d;
  logic          out_valid_q, out_valid_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic          done_q, done_d;
  logic [SW-1:0] cap_q [NUM_NEURON];
  logic [SW-1:0] cap_d [NUM_NEURON];

  function automatic logic [SW-1:0] rectify(input logic [SW-1:0] s);
`ifdef LAYER_SEQ_RELU_EN
    return s[SW-1] ? '0 : s;
`else
    return s;
`endif
  endfunction

  // Next state; the capture array doubles as an output shift register during DRAIN.
  always_comb begin
    state_d     = state_q;
    in_addr_d   = in_addr_q;
    freeze_d    = freeze_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    done_d      = 1'b0;
    cap_d       = cap_q;
    unique case (state_q)
      S_IDLE: begin
        in_addr_d = '0;
        freeze_d  = 1'b1;
        if (start) begin
          state_d  = S_RUN;
          freeze_d = 1'b0;
        end
      end
      S_RUN: begin
        if (in_addr_q == LAST_ADDR) begin
          state_d   = S_CAPTURE;
          in_addr_d = '0;
          freeze_d  = 1'b1;
        end else begin
          in_addr_d = in_addr_q + AW'(1);
        end
      end
      S_CAPTURE: begin
        for (int n = 0; n < int'(NUM_NEURON); n++) begin
          cap_d[n] = rectify(sums_in[n*SW +: SW]);
        end
        state_d     = S_DRAIN;
        out_valid_d = 1'b1;
        out_idx_d   = '0;
      end
      S_DRAIN: begin
        if (out_if.out_ready) begin
          for (int n = 0; n < int'(NUM_NEURON) - 1; n++) begin
            cap_d[n] = cap_q[n+1];
          end
          cap_d[NUM_NEURON-1] = '0;
          if (out_idx_q == LAST_IDX) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_idx_d   = '0;
            done_d      = 1'b1;
          end else begin
            out_idx_d = out_idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      freeze_q    <= 1'b1;
      in_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
      for (int n = 0; n < int'(NUM_NEURON); n++) cap_q[n] <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      freeze_q    <= freeze_d;
      in_addr_q   <= in_addr_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      done_q      <= done_d;
      cap_q       <= cap_d;
    end
  end

  assign busy             = busy_q;
  assign freeze           = freeze_q;
  assign in_addr          = in_addr_q;
  assign done             = done_q;
  assign myinput          = in_data;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_idx   = out_idx_q;
  assign out_if.out_data  = cap_q[0];

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: behavioural neurons, async-read input buffer and a result scoreboard.
module tb_layer_sequencer;
  localparam int unsigned NW = 4;
  localparam int unsigned NN = 2;
  localparam int unsigned DW = 16;
  localparam int unsigned SW = 32;
  localparam int unsigned IW = 1;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  logic                 clk, rst_n, start, busy, freeze, done;
  logic [1:0]           in_addr;
  logic [DW-1:0]        in_data, myinput;
  logic [NN*SW-1:0]     sums_in;

  layer_sequencer_if #(.DATA_WIDTH(DW), .NUM_NEURON(NN)) out_if ();

  layer_sequencer #(.NUM_WEIGHT(NW), .NUM_NEURON(NN), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .in_addr(in_addr),
    .in_data(in_data), .freeze(freeze), .myinput(myinput), .sums_in(sums_in),
    .out_if(out_if), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  logic signed [15:0] in_mem [NW];
  logic signed [15:0] w [NN][NW];
  logic signed [31:0] bias [NN];
  logic signed [31:0] acc [NN];
  logic [31:0]        fixed_sums [NN];
  logic               use_model;
  int                 kaddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign in_data = in_mem[in_addr];

  // Behavioural neuron_no_ReLU: frozen clears, otherwise MAC with bias on the last element.
  always @(posedge clk) begin
    if (freeze) begin
      kaddr <= 0;
      for (int n = 0; n < NN; n++) acc[n] <= 32'sd0;
    end else if (kaddr < NW) begin
      kaddr <= kaddr + 1;
      for (int n = 0; n < NN; n++)
        acc[n] <= acc[n] + 32'($signed(myinput)) * 32'(w[n][kaddr])
                  + ((kaddr == NW - 1) ? bias[n] : 32'sd0);
    end
  end

  always_comb begin
    sums_in = '0;
    for (int n = 0; n < NN; n++)
      sums_in[n*SW +: SW] = use_model ? acc[n] : fixed_sums[n];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_random();
    int b;
    for (int k = 0; k < NW; k++) in_mem[k] = 16'($urandom);
    for (int n = 0; n < NN; n++) begin
      for (int k = 0; k < NW; k++) w[n][k] = 16'($urandom);
      b = int'($urandom_range(0, 2000));
      bias[n] = 32'(b - 1000);
    end
  endtask

  function automatic logic [31:0] ref_sum(int n);
    logic signed [31:0] s;
    s = bias[n];
    for (int k = 0; k < NW; k++) s = s + 32'(in_mem[k]) * 32'(w[n][k]);
`ifdef LAYER_SEQ_RELU_EN
    if (s[31]) s = '0;
`endif
    return s;
  endfunction

  task automatic push_expected();
    exp_t e;
    for (int n = 0; n < NN; n++) begin
      e.idx  = n;
      e.data = ref_sum(n);
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL reset_freeze: got %b expected 1", freeze); end
    n_checks++; if (in_addr !== 2'd0) begin n_fail++; $display("FAIL reset_in_addr: got %0d expected 0", in_addr); end
    n_checks++; if (out_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_if.out_valid); end
    n_checks++; if (out_if.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_if.out_data); end
    n_checks++; if (out_if.out_idx !== 1'b0) begin n_fail++; $display("FAIL reset_out_idx: got %0d expected 0", out_if.out_idx); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    exp_t e;
    int budget;
    load_random();
    push_expected();
    out_if.out_ready = 1'b1;
    pulse_start();
    for (int c = 1; c <= NW; c++) begin
      n_checks++;
      if (freeze !== 1'b0 || in_addr !== 2'(c - 1) || busy !== 1'b1) begin
        n_fail++; $display("FAIL basic_run c%0d: freeze %b addr %0d busy %b expected 0 %0d 1", c, freeze, in_addr, busy, c - 1);
      end
      tick();
    end
    n_checks++;
    if (freeze !== 1'b1 || out_if.out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_capture: freeze %b valid %b busy %b expected 1 0 1", freeze, out_if.out_valid, busy);
    end
    tick();
    budget = 0;
    while (sb.size() != 0 && budget < 40) begin
      if (out_if.out_valid && out_if.out_ready) begin
        e = sb.pop_front(); n_checks++;
        if (out_if.out_data !== e.data || out_if.out_idx !== IW'(e.idx)) begin
          n_fail++; $display("FAIL basic_word: got idx %0d data %h expected idx %0d data %h", out_if.out_idx, out_if.out_data, e.idx, e.data);
        end
      end
      tick(); budget++;
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL basic_timeout: %0d words left expected 0", sb.size()); sb.delete(); end
    n_checks++; if (budget != NN) begin n_fail++; $display("FAIL basic_drain_len: got %0d cycles expected %0d", budget, NN); end
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: done %b busy %b expected 1 0", done, busy); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int budget;
    load_random();
    push_expected();
    out_if.out_ready = 1'b0;
    pulse_start();
    repeat (NW + 1) tick();
    for (int s = 0; s < 5; s++) begin
      n_checks++;
      if (out_if.out_valid !== 1'b1 || out_if.out_idx !== 1'b0 || out_if.out_data !== sb[0].data || done !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold s%0d: valid %b idx %0d data %h done %b expected 1 0 %h 0", s, out_if.out_valid, out_if.out_idx, out_if.out_data, done, sb[0].data);
      end
      tick();
    end
    out_if.out_ready = 1'b1;
    budget = 0;
    while (sb.size() != 0 && budget < 40) begin
      if (out_if.out_valid && out_if.out_ready) begin
        e = sb.pop_front(); n_checks++;
        if (out_if.out_data !== e.data || out_if.out_idx !== IW'(e.idx)) begin
          n_fail++; $display("FAIL bp_word: got idx %0d data %h expected idx %0d data %h", out_if.out_idx, out_if.out_data, e.idx, e.data);
        end
      end
      tick(); budget++;
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL bp_timeout: %0d words left expected 0", sb.size()); sb.delete(); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b expected 1", done); end
    tick();
  endtask

  task automatic test_values();
    exp_t e;
    int budget;
    use_model = 1'b0;
    fixed_sums[0] = 32'h0000000A;
    fixed_sums[1] = 32'hFFFFFFF6;
    e.idx = 0; e.data = 32'h0000000A; sb.push_back(e);
`ifdef LAYER_SEQ_RELU_EN
    e.idx = 1; e.data = 32'h00000000; sb.push_back(e);
`else
    e.idx = 1; e.data = 32'hFFFFFFF6; sb.push_back(e);
`endif
    pulse_start();
    repeat (NW + 1) tick();
    budget = 0;
    while (sb.size() != 0 && budget < 40) begin
      if (out_if.out_valid && out_if.out_ready) begin
        e = sb.pop_front(); n_checks++;
        if (out_if.out_data !== e.data || out_if.out_idx !== IW'(e.idx)) begin
          n_fail++; $display("FAIL values_word: got idx %0d data %h expected idx %0d data %h", out_if.out_idx, out_if.out_data, e.idx, e.data);
        end
      end
      tick(); budget++;
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL values_timeout: %0d words left expected 0", sb.size()); sb.delete(); end
    use_model = 1'b1;
    tick();
  endtask

  task automatic test_start_ignored();
    exp_t e;
    int runs, dones;
    runs = 0; dones = 0;
    load_random();
    push_expected();
    pulse_start();
    for (int c = 1; c <= 15; c++) begin
      if (freeze === 1'b0) runs++;
      if (done === 1'b1) dones++;
      if (out_if.out_valid && out_if.out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL ign_extra_word: got idx %0d expected none", out_if.out_idx);
        end else begin
          e = sb.pop_front();
          if (out_if.out_data !== e.data || out_if.out_idx !== IW'(e.idx)) begin
            n_fail++; $display("FAIL ign_word: got idx %0d data %h expected idx %0d data %h", out_if.out_idx, out_if.out_data, e.idx, e.data);
          end
        end
      end
      start = (c == 2 || c == 6);
      tick();
    end
    start = 1'b0;
    n_checks++; if (runs != NW) begin n_fail++; $display("FAIL ign_run_cycles: got %0d expected %0d", runs, NW); end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL ign_done_count: got %0d expected 1", dones); end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL ign_words_left: got %0d expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int budget;
    load_random();
    pulse_start();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (freeze !== 1'b1 || busy !== 1'b0 || in_addr !== 2'd0 || out_if.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state: freeze %b busy %b addr %0d valid %b expected 1 0 0 0", freeze, busy, in_addr, out_if.out_valid);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    load_random();
    push_expected();
    pulse_start();
    for (int c = 1; c <= NW; c++) begin
      n_checks++;
      if (freeze !== 1'b0 || in_addr !== 2'(c - 1)) begin
        n_fail++; $display("FAIL midrst_run c%0d: freeze %b addr %0d expected 0 %0d", c, freeze, in_addr, c - 1);
      end
      tick();
    end
    tick();
    budget = 0;
    while (sb.size() != 0 && budget < 40) begin
      if (out_if.out_valid && out_if.out_ready) begin
        e = sb.pop_front(); n_checks++;
        if (out_if.out_data !== e.data || out_if.out_idx !== IW'(e.idx)) begin
          n_fail++; $display("FAIL midrst_word: got idx %0d data %h expected idx %0d data %h", out_if.out_idx, out_if.out_data, e.idx, e.data);
        end
      end
      tick(); budget++;
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL midrst_timeout: %0d words left expected 0", sb.size()); sb.delete(); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL midrst_done: got %b expected 1", done); end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int budget;
    load_random();
    push_expected();
    pulse_start();
    repeat (NW + 1) tick();
    for (int pass = 0; pass < 2; pass++) begin
      budget = 0;
      while (sb.size() != 0 && budget < 40) begin
        if (out_if.out_valid && out_if.out_ready) begin
          e = sb.pop_front(); n_checks++;
          if (out_if.out_data !== e.data || out_if.out_idx !== IW'(e.idx)) begin
            n_fail++; $display("FAIL b2b_word p%0d: got idx %0d data %h expected idx %0d data %h", pass, out_if.out_idx, out_if.out_data, e.idx, e.data);
          end
        end
        tick(); budget++;
      end
      n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_timeout p%0d: %0d words left expected 0", pass, sb.size()); sb.delete(); end
      n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done p%0d: done %b busy %b expected 1 0", pass, done, busy); end
      if (pass == 0) begin
        load_random();
        push_expected();
        pulse_start();
        n_checks++;
        if (freeze !== 1'b0 || in_addr !== 2'd0 || busy !== 1'b1) begin
          n_fail++; $display("FAIL b2b_restart: freeze %b addr %0d busy %b expected 0 0 1", freeze, in_addr, busy);
        end
        repeat (NW + 1) tick();
      end
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    use_model = 1'b1;
    out_if.out_ready = 1'b1;
    for (int n = 0; n < NN; n++) fixed_sums[n] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_values();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
